// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two requester FIFOs drained round-robin into a registered
// regfile write stage, with read-port bypass and pending-write snooping.
module regfile_wb_arbiter #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_reg,
   input  logic [63:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_reg,
   input  logic [63:0] b_data,
   input  logic        hold,
   output logic        RegWrite,
   output logic [4:0]  WriteRegister,
   output logic [63:0] WriteData,
   input  logic [4:0]  ReadRegister1,
   input  logic [4:0]  ReadRegister2,
   output logic        Bypass1,
   output logic        Bypass2,
   output logic [63:0] BypassData1,
   output logic [63:0] BypassData2,
   output logic        Pending1,
   output logic        Pending2
);
   localparam int unsigned   PW   = $clog2(DEPTH);
   localparam int unsigned   CW   = $clog2(DEPTH + 1);
   localparam logic [4:0]    ZR   = 5'(ZERO_REG);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {GRANT_A, GRANT_B} grant_t;

   logic [1:0]    in_valid;
   logic [1:0]    ready;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic [1:0]    nonempty;
   logic [4:0]    in_reg    [2];
   logic [63:0]   in_data   [2];
   logic [4:0]    fifo_reg  [2][DEPTH];
   logic [63:0]   fifo_data [2][DEPTH];
   logic [PW-1:0] wptr      [2];
   logic [PW-1:0] rptr      [2];
   logic [CW-1:0] count     [2];

   grant_t        last_grant;
   grant_t        last_grant_nxt;

   logic          stage_valid;
   logic [4:0]    stage_reg;
   logic [63:0]   stage_data;

   assign in_valid   = {b_valid, a_valid};
   assign in_reg[0]  = a_reg;
   assign in_reg[1]  = b_reg;
   assign in_data[0] = a_data;
   assign in_data[1] = b_data;

   // ready depends only on the registered count, so a full FIFO refuses even
   // when its head is being popped this cycle
   always_comb begin
      ready    = '0;
      nonempty = '0;
      push     = '0;
      for (int unsigned r = 0; r < 2; r++) begin
         ready[r]    = (count[r] != FULL);
         nonempty[r] = (count[r] != '0);
         push[r]     = in_valid[r] & ready[r] & (in_reg[r] != ZR);
      end
   end

   assign a_ready = ready[0];
   assign b_ready = ready[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < 2; r++) begin
            wptr[r]  <= '0;
            rptr[r]  <= '0;
            count[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < 2; r++) begin
            if (push[r]) begin
               fifo_reg[r][wptr[r]]  <= in_reg[r];
               fifo_data[r][wptr[r]] <= in_data[r];
               wptr[r]               <= wptr[r] + PW'(1);
            end
            if (pop[r]) begin
               rptr[r] <= rptr[r] + PW'(1);
            end
            count[r] <= count[r] + CW'(push[r]) - CW'(pop[r]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= GRANT_B;
      end else begin
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      last_grant_nxt = last_grant;
      if (pop[0]) begin
         last_grant_nxt = GRANT_A;
      end else if (pop[1]) begin
         last_grant_nxt = GRANT_B;
      end
   end

   always_comb begin
      pop = '0;
      if (!hold) begin
         if (nonempty[0] && (!nonempty[1] || last_grant == GRANT_B)) begin
            pop[0] = 1'b1;
         end else if (nonempty[1]) begin
            pop[1] = 1'b1;
         end
      end
   end

   // with no grant only the valid bit drops; reg/data keep their last value
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_valid <= 1'b0;
         stage_reg   <= '0;
         stage_data  <= '0;
      end else if (!hold) begin
         stage_valid <= |pop;
         if (pop[0]) begin
            stage_reg  <= fifo_reg[0][rptr[0]];
            stage_data <= fifo_data[0][rptr[0]];
         end else if (pop[1]) begin
            stage_reg  <= fifo_reg[1][rptr[1]];
            stage_data <= fifo_data[1][rptr[1]];
         end
      end
   end

   assign RegWrite      = stage_valid & ~hold;
   assign WriteRegister = stage_reg;
   assign WriteData     = stage_data;

   assign Bypass1     = RegWrite & (ReadRegister1 == stage_reg);
   assign Bypass2     = RegWrite & (ReadRegister2 == stage_reg);
   assign BypassData1 = Bypass1 ? stage_data : '0;
   assign BypassData2 = Bypass2 ? stage_data : '0;

   // walk only the occupied slots, starting at each FIFO's read pointer
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      Pending1 = 1'b0;
      Pending2 = 1'b0;
      for (int unsigned r = 0; r < 2; r++) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count[r]) begin
               idx = rptr[r] + PW'(k);
               if (fifo_reg[r][idx] == ReadRegister1) begin
                  Pending1 = 1'b1;
               end
               if (fifo_reg[r][idx] == ReadRegister2) begin
                  Pending2 = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a random run, with a
// per-requester scoreboard checking every issued write and its bypass outputs.
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid, hold;
   logic        a_ready, b_ready;
   logic [4:0]  a_reg, b_reg;
   logic [63:0] a_data, b_data;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [4:0]  ReadRegister1, ReadRegister2;
   logic        Bypass1, Bypass2, Pending1, Pending2;
   logic [63:0] BypassData1, BypassData2;

   int vectors     = 0;
   int miscompares = 0;

   logic [68:0] qa[$];
   logic [68:0] qb[$];
   bit          owner_b [32];

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DEPTH(2), .ZERO_REG(31)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .hold(hold),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .Bypass1(Bypass1), .Bypass2(Bypass2),
      .BypassData1(BypassData1), .BypassData2(BypassData2),
      .Pending1(Pending1), .Pending2(Pending2)
   );

   // Scoreboard: compare each issued write against the owning requester's
   // queue head, then record handshakes that complete at the coming edge.
   always @(negedge clk) begin : monitor
      logic [68:0] e;
      logic        eb1, eb2;
      bit          from_b;
      vectors++;
      if (RegWrite === 1'b1) begin
         from_b = owner_b[WriteRegister];
         if (from_b ? (qb.size() == 0) : (qa.size() == 0)) begin
            miscompares++;
            $display("FAIL sb_unexpected_write: got reg %0d data %h, required no write", WriteRegister, WriteData);
         end else begin
            e = from_b ? qb.pop_front() : qa.pop_front();
            if ({WriteRegister, WriteData} !== e) begin
               miscompares++;
               $display("FAIL sb_write_order: got reg %0d data %h, required reg %0d data %h",
                        WriteRegister, WriteData, e[68:64], e[63:0]);
            end
            eb1 = (ReadRegister1 == e[68:64]);
            eb2 = (ReadRegister2 == e[68:64]);
            vectors++;
            if ({Bypass1, BypassData1, Bypass2, BypassData2} !==
                {eb1, eb1 ? e[63:0] : 64'd0, eb2, eb2 ? e[63:0] : 64'd0}) begin
               miscompares++;
               $display("FAIL sb_bypass: got %b/%h %b/%h, required %b/%h %b/%h",
                        Bypass1, BypassData1, Bypass2, BypassData2,
                        eb1, eb1 ? e[63:0] : 64'd0, eb2, eb2 ? e[63:0] : 64'd0);
            end
         end
      end else if ({Bypass1, Bypass2, BypassData1, BypassData2} !== '0) begin
         miscompares++;
         $display("FAIL sb_bypass_idle: got %b %b %h %h, required all 0",
                  Bypass1, Bypass2, BypassData1, BypassData2);
      end
      if (reset === 1'b1) begin
         qa.delete();
         qb.delete();
      end else begin
         if (a_valid && a_ready && a_reg != 5'd31) begin
            qa.push_back({a_reg, a_data});
            owner_b[a_reg] = 1'b0;
         end
         if (b_valid && b_ready && b_reg != 5'd31) begin
            qb.push_back({b_reg, b_data});
            owner_b[b_reg] = 1'b1;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      a_valid = 1'b0;
      b_valid = 1'b0;
      hold    = 1'b0;
      for (int i = 0; i < n; i++) begin
         next_cycle();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
      a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
      ReadRegister1 = '0; ReadRegister2 = '0;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
      end
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if ({a_ready, b_ready, RegWrite, WriteRegister, WriteData, Bypass1, Bypass2,
           BypassData1, BypassData2, Pending1, Pending2} !==
          {1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_values: got rdy %b%b rw %b wr %0d wd %h byp %b%b pend %b%b, required rdy 11 rw 0 wr 0 wd 0 byp 00 pend 00",
                  a_ready, b_ready, RegWrite, WriteRegister, WriteData, Bypass1, Bypass2, Pending1, Pending2);
      end
      next_cycle();
   endtask

   task automatic test_contention();
      logic [4:0] alist [3];
      logic [4:0] blist [3];
      logic [4:0] want  [6];
      logic [4:0] seen  [$];
      int ai = 0, bi = 0, first_c = -1, last_c = -1, a_low = 0, b_low = 0;
      alist = '{5'd1, 5'd2, 5'd3};
      blist = '{5'd11, 5'd12, 5'd13};
      want  = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
      for (int c = 0; c < 30 && seen.size() < 6; c++) begin
         a_valid = (ai < 3);
         b_valid = (bi < 3);
         if (ai < 3) begin a_reg = alist[ai]; a_data = 64'hA000 + 64'(ai); end
         if (bi < 3) begin b_reg = blist[bi]; b_data = 64'hB000 + 64'(bi); end
         @(negedge clk);
         if (!a_ready) a_low++;
         if (!b_ready) b_low++;
         if (a_valid && a_ready) ai++;
         if (b_valid && b_ready) bi++;
         if (RegWrite) begin
            seen.push_back(WriteRegister);
            if (first_c < 0) first_c = c;
            last_c = c;
         end
         next_cycle();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      vectors++;
      if (seen.size() != 6) begin
         miscompares++;
         $display("FAIL contention_count: got %0d writes, required 6", seen.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            vectors++;
            if (seen[i] !== want[i]) begin
               miscompares++;
               $display("FAIL contention_order[%0d]: got reg %0d, required %0d", i, seen[i], want[i]);
            end
         end
      end
      vectors++;
      if (first_c != 2 || last_c != 7) begin
         miscompares++;
         $display("FAIL contention_timing: got cycles %0d..%0d, required 2..7", first_c, last_c);
      end
      vectors++;
      if (a_low != 1 || b_low != 2) begin
         miscompares++;
         $display("FAIL contention_ready_drop: got a_low %0d b_low %0d, required 1 and 2", a_low, b_low);
      end
      idle(3);
   endtask

   task automatic test_single();
      for (int c = 0; c < 4; c++) begin
         a_valid = (c == 0);
         a_reg = 5'd5; a_data = 64'h1234;
         ReadRegister1 = 5'd5; ReadRegister2 = 5'd6;
         @(negedge clk);
         vectors++;
         case (c)
            0: if (a_ready !== 1'b1) begin
                  miscompares++;
                  $display("FAIL single_ready: got %b, required 1", a_ready);
               end
            1: if ({RegWrite, Pending1, Pending2, Bypass1} !== 4'b0100) begin
                  miscompares++;
                  $display("FAIL single_pending: got rw/p1/p2/b1 %b%b%b%b, required 0100", RegWrite, Pending1, Pending2, Bypass1);
               end
            2: if ({RegWrite, WriteRegister, WriteData, Bypass1, BypassData1, Bypass2, Pending1} !==
                   {1'b1, 5'd5, 64'h1234, 1'b1, 64'h1234, 1'b0, 1'b0}) begin
                  miscompares++;
                  $display("FAIL single_write: got rw %b wr %0d wd %h b1 %b bd1 %h b2 %b p1 %b, required 1 5 1234 1 1234 0 0",
                           RegWrite, WriteRegister, WriteData, Bypass1, BypassData1, Bypass2, Pending1);
               end
            default: if ({RegWrite, Bypass1, BypassData1} !== 66'd0) begin
                  miscompares++;
                  $display("FAIL single_after: got rw %b b1 %b bd1 %h, required 0 0 0", RegWrite, Bypass1, BypassData1);
               end
         endcase
         next_cycle();
      end
      idle(2);
   endtask

   task automatic test_xzr();
      for (int c = 0; c < 5; c++) begin
         a_valid = (c < 2);
         a_reg   = (c == 0) ? 5'd31 : 5'd4;
         a_data  = (c == 0) ? 64'hDEAD : 64'h44;
         ReadRegister1 = (c <= 1) ? 5'd31 : 5'd4;
         ReadRegister2 = 5'd9;
         @(negedge clk);
         vectors++;
         case (c)
            0: if (a_ready !== 1'b1) begin
                  miscompares++;
                  $display("FAIL xzr_ready: got %b, required 1", a_ready);
               end
            1: if ({RegWrite, Pending1, a_ready} !== 3'b001) begin
                  miscompares++;
                  $display("FAIL xzr_not_queued: got rw/p1/rdy %b%b%b, required 001", RegWrite, Pending1, a_ready);
               end
            2: if ({RegWrite, Pending1, Pending2} !== 3'b010) begin
                  miscompares++;
                  $display("FAIL xzr_reg4_pending: got rw/p1/p2 %b%b%b, required 010", RegWrite, Pending1, Pending2);
               end
            3: if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd4, 64'h44}) begin
                  miscompares++;
                  $display("FAIL xzr_reg4_write: got rw %b wr %0d wd %h, required 1 4 44", RegWrite, WriteRegister, WriteData);
               end
            default: if (RegWrite !== 1'b0) begin
                  miscompares++;
                  $display("FAIL xzr_after: got rw %b, required 0", RegWrite);
               end
         endcase
         next_cycle();
      end
      idle(2);
   endtask

   task automatic test_hold();
      logic [4:0] want [5];
      want = '{5'd7, 5'd17, 5'd8, 5'd18, 5'd9};
      for (int c = 0; c < 12; c++) begin
         a_valid = (c == 0) || (c == 2) || (c == 3);
         b_valid = (c == 2) || (c == 3);
         a_reg   = (c == 0) ? 5'd7 : ((c == 2) ? 5'd8 : 5'd9);
         b_reg   = (c == 2) ? 5'd17 : 5'd18;
         a_data  = 64'h700 + 64'(a_reg);
         b_data  = 64'hB00 + 64'(b_reg);
         hold    = (c >= 2) && (c <= 5);
         ReadRegister1 = 5'd7; ReadRegister2 = 5'd8;
         @(negedge clk);
         if (c == 2) begin
            vectors++;
            if ({RegWrite, WriteRegister, Pending1, Bypass1} !== {1'b0, 5'd7, 1'b0, 1'b0}) begin
               miscompares++;
               $display("FAIL hold_stage: got rw %b wr %0d p1 %b b1 %b, required 0 7 0 0", RegWrite, WriteRegister, Pending1, Bypass1);
            end
         end else if (c == 3) begin
            vectors++;
            if ({RegWrite, Pending2} !== 2'b01) begin
               miscompares++;
               $display("FAIL hold_pending: got rw/p2 %b%b, required 01", RegWrite, Pending2);
            end
         end else if (c == 4 || c == 5) begin
            vectors++;
            if ({RegWrite, a_ready, b_ready} !== 3'b000) begin
               miscompares++;
               $display("FAIL hold_full[%0d]: got rw/ar/br %b%b%b, required 000", c, RegWrite, a_ready, b_ready);
            end
         end else if (c >= 6 && c <= 10) begin
            vectors++;
            if ({RegWrite, WriteRegister} !== {1'b1, want[c-6]}) begin
               miscompares++;
               $display("FAIL hold_release[%0d]: got rw %b wr %0d, required 1 %0d", c, RegWrite, WriteRegister, want[c-6]);
            end
         end else if (c == 11) begin
            vectors++;
            if (RegWrite !== 1'b0) begin
               miscompares++;
               $display("FAIL hold_drained: got rw %b, required 0", RegWrite);
            end
         end
         next_cycle();
      end
      idle(2);
   endtask

   task automatic test_reset_midstream();
      for (int c = 0; c < 10; c++) begin
         a_valid = (c <= 2);
         b_valid = (c <= 2);
         a_reg   = 5'(c + 1);
         b_reg   = 5'(c + 11);
         a_data  = 64'hC00 + 64'(c);
         b_data  = 64'hD00 + 64'(c);
         hold    = (c == 2) || (c == 3) || (c == 4);
         reset   = (c == 4);
         ReadRegister1 = 5'd2; ReadRegister2 = 5'd12;
         @(negedge clk);
         if (c == 3) begin
            vectors++;
            if ({RegWrite, a_ready, b_ready} !== 3'b000 || (WriteRegister != 5'd1 && WriteRegister != 5'd11)) begin
               miscompares++;
               $display("FAIL midreset_before: got rw/ar/br %b%b%b wr %0d, required 000 wr 1 or 11",
                        RegWrite, a_ready, b_ready, WriteRegister);
            end
         end else if (c == 5) begin
            vectors++;
            if ({RegWrite, a_ready, b_ready, WriteRegister, WriteData, Pending1, Pending2} !==
                {3'b011, 5'd0, 64'd0, 2'b00}) begin
               miscompares++;
               $display("FAIL midreset_after: got rw/ar/br %b%b%b wr %0d wd %h p %b%b, required 011 0 0 00",
                        RegWrite, a_ready, b_ready, WriteRegister, WriteData, Pending1, Pending2);
            end
         end else if (c > 5) begin
            vectors++;
            if (RegWrite !== 1'b0) begin
               miscompares++;
               $display("FAIL midreset_stale[%0d]: got rw %b wr %0d, required 0", c, RegWrite, WriteRegister);
            end
         end
         next_cycle();
      end
      idle(2);
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 10000; c++) begin
         a_valid = 1'($urandom_range(0, 1));
         b_valid = 1'($urandom_range(0, 1));
         r = int'($urandom_range(0, 15));
         a_reg = (r == 15) ? 5'd31 : 5'(r);
         b_reg = 5'($urandom_range(15, 30));
         a_data = {$urandom(), $urandom()};
         b_data = {$urandom(), $urandom()};
         hold = ($urandom_range(0, 7) == 0);
         ReadRegister1 = 5'($urandom_range(0, 31));
         ReadRegister2 = 5'($urandom_range(0, 31));
         next_cycle();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      hold = 1'b0;
      for (int c = 0; c < 40 && (qa.size() != 0 || qb.size() != 0); c++) begin
         next_cycle();
      end
      idle(4);
      vectors++;
      if (qa.size() != 0 || qb.size() != 0) begin
         miscompares++;
         $display("FAIL random_drain: got %0d A and %0d B writes never issued, required 0 and 0", qa.size(), qb.size());
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_xzr();
      test_hold();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
